// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: takes a WIDTH-bit word on a valid/ready
// handshake and shifts it out one bit per clock with frame and end-of-word strobes.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             ser_o,
    output logic             frame_o,
    output logic             done_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ser_q, ser_d;
    logic             frame_q, frame_d;
    logic             done_q, done_d;

    logic             accept;
    logic             load_ser;
    logic [WIDTH-1:0] load_sh;
    logic             next_ser;
    logic [WIDTH-1:0] next_sh;

    // Ready only when idle or when the last bit of the current word is on the line.
    assign ready_o = !rst_i && (state_q == IDLE || cnt_q == '0);
    assign accept  = valid_i && ready_o;

    // sh always holds the not-yet-sent bits, aligned so the next one sits at the exit end.
    always_comb begin
        if (MSB_FIRST) begin
            load_ser = data_i[WIDTH-1];
            load_sh  = {data_i[WIDTH-2:0], 1'b0};
            next_ser = sh_q[WIDTH-1];
            next_sh  = {sh_q[WIDTH-2:0], 1'b0};
        end else begin
            load_ser = data_i[0];
            load_sh  = {1'b0, data_i[WIDTH-1:1]};
            next_ser = sh_q[0];
            next_sh  = {1'b0, sh_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        ser_d   = 1'b0;
        frame_d = 1'b0;
        done_d  = 1'b0;
        if (accept) begin
            state_d = SHIFT;
            sh_d    = load_sh;
            cnt_d   = CNT_LAST;
            ser_d   = load_ser;
            frame_d = 1'b1;
        end else if (state_q == SHIFT && cnt_q != '0) begin
            sh_d    = next_sh;
            cnt_d   = cnt_q - CNT_ONE;
            ser_d   = next_ser;
            frame_d = 1'b1;
            done_d  = (cnt_q == CNT_ONE);
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            ser_q   <= 1'b0;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            ser_q   <= ser_d;
            frame_q <= frame_d;
            done_q  <= done_d;
        end
    end

    assign ser_o   = ser_q;
    assign frame_o = frame_q;
    assign done_o  = done_q;

endmodule
